// File: rtl/serial_code_converter.sv
// Bit-serial LSB-first decimal code converter: adds or subtracts OFFSET per 4-bit digit,
// with a Mealy output bit, per-digit illegal-code flag and frame counting.
module serial_code_converter #(
    parameter int unsigned OFFSET     = 3,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             X,
    input  logic             Valid,
    input  logic             Mode,
    input  logic             Clr,
    output logic             Z,
    output logic             DigitDone,
    output logic             Err,
    output logic             FrameDone,
    output logic [IDX_W-1:0] DigitIdx
);

    // Bit position within the current digit.
    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    localparam logic [3:0]       OFF      = 4'(OFFSET);
    localparam logic [4:0]       HI_LIMIT = 5'(9 + OFFSET);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [1:0]       state_q, state_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic [2:0]       shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_q, frame_d;

    logic             k;
    logic             cin;
    logic             eff_mode;
    logic             xe;
    logic             carry_nxt;
    logic [3:0]       code;
    logic             bad_code;

    // State register; pulse flags are recomputed every cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= B0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            shift_q <= 3'd0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    // Serial add/subtract datapath, next-state and Mealy output.
    always_comb begin
        state_d   = state_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        frame_d   = 1'b0;

        k         = OFF[state_q];
        cin       = (state_q == B0) ? 1'b0 : carry_q;
        eff_mode  = (state_q == B0) ? Mode : mode_q;
        // Subtraction borrow is the add-carry majority with X inverted.
        xe        = eff_mode ? X : ~X;
        carry_nxt = (xe & k) | (xe & cin) | (k & cin);
        // Bit 3 of the input code is the bit arriving now, so it is never stored.
        code      = {X, shift_q};
        bad_code  = eff_mode ? (code > 4'd9)
                             : (carry_nxt | ({1'b0, code} > HI_LIMIT));
        Z         = Valid & (X ^ k ^ cin);

        if (Clr) begin
            state_d = B0;
            carry_d = 1'b0;
            mode_d  = 1'b0;
            shift_d = 3'd0;
            idx_d   = '0;
        end else if (Valid) begin
            carry_d = carry_nxt;
            case (state_q)
                B0: begin
                    mode_d     = Mode;
                    shift_d[0] = X;
                    state_d    = B1;
                end
                B1: begin
                    shift_d[1] = X;
                    state_d    = B2;
                end
                B2: begin
                    shift_d[2] = X;
                    state_d    = B3;
                end
                default: begin
                    state_d = B0;
                    done_d  = 1'b1;
                    err_d   = bad_code;
                    frame_d = (idx_q == LAST_IDX);
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end
            endcase
        end
    end

    assign DigitDone = done_q;
    assign Err       = err_q;
    assign FrameDone = frame_q;
    assign DigitIdx  = idx_q;

endmodule
